// File: rtl/free_list_ckpt_if.sv
// Request/grant bundle for the checkpointed physical-name free list.
// The master drives the requests and the slave (the free list) returns the grants and status.
interface free_list_ckpt_if #(
    parameter int pBitVecW = 16,
    parameter int pAlcIO   = 4,
    parameter int pDeAlcIO = 8,
    parameter int pCkpt    = 4
);
    localparam int NW = $clog2(pBitVecW);
    localparam int CW = (pCkpt > 1) ? $clog2(pCkpt) : 1;
    localparam int FW = $clog2(pBitVecW + 1);

    logic [pAlcIO-1:0]            AllocReq;
    logic [pAlcIO-1:0]            AllocVld;
    logic [pAlcIO-1:0][NW-1:0]    AllocPhy;
    logic [pDeAlcIO-1:0]          DeAllocReq;
    logic [pDeAlcIO-1:0][NW-1:0]  DeAllocPhy;
    logic                         CkptReq;
    logic                         CkptVld;
    logic [CW-1:0]                CkptId;
    logic                         CkptFull;
    logic [pCkpt-1:0]             CkptFreeMask;
    logic                         RestoreReq;
    logic [CW-1:0]                RestoreId;
    logic [FW-1:0]                FreeCnt;
    logic                         FreeListEmpty;

    modport master (
        output AllocReq, DeAllocReq, DeAllocPhy, CkptReq, CkptFreeMask, RestoreReq, RestoreId,
        input  AllocVld, AllocPhy, CkptVld, CkptId, CkptFull, FreeCnt, FreeListEmpty
    );

    modport slave (
        input  AllocReq, DeAllocReq, DeAllocPhy, CkptReq, CkptFreeMask, RestoreReq, RestoreId,
        output AllocVld, AllocPhy, CkptVld, CkptId, CkptFull, FreeCnt, FreeListEmpty
    );
endinterface

// File: rtl/free_list_ckpt.sv
// Physical-name free list with same-cycle multi-port allocation, multi-port frees,
// and checkpoint snapshots of the busy vector that can be restored on a rollback.
module free_list_ckpt #(
    parameter int pBitVecW = 16,
    parameter int pAlcIO   = 4,
    parameter int pDeAlcIO = 8,
    parameter int pCkpt    = 4,
    parameter int pHwPhy0  = 1,
    parameter int pEnFwd   = 1
) (
    input logic             Clk,
    input logic             Clr,
    free_list_ckpt_if.slave bus
);
    localparam int NW = $clog2(pBitVecW);
    localparam int CW = (pCkpt > 1) ? $clog2(pCkpt) : 1;
    localparam int FW = $clog2(pBitVecW + 1);
    localparam logic [pBitVecW-1:0] BV_RST = (pHwPhy0 != 0) ? pBitVecW'(1) : '0;
    localparam logic [FW-1:0]       CNT_RST = FW'(pBitVecW - ((pHwPhy0 != 0) ? 1 : 0));

    logic [pBitVecW-1:0] bv_q, bv_d;
    logic [pBitVecW-1:0] sv_q [pCkpt];
    logic [pBitVecW-1:0] sv_d [pCkpt];
    logic [pCkpt-1:0]    cv_q, cv_d;
    logic [FW-1:0]       free_cnt_q, free_cnt_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;

    logic [pBitVecW-1:0]         dealloc_set;
    logic [pBitVecW-1:0]         avail;
    logic [pBitVecW-1:0]         remain;
    logic [pBitVecW-1:0]         grant_set;
    logic                        pick_found;
    logic [pAlcIO-1:0]           alloc_vld;
    logic [pAlcIO-1:0][NW-1:0]   alloc_phy;
    logic                        ckpt_vld;
    logic [CW-1:0]               ckpt_id;

    // One decoder per name: the name is freed if any free port names it.
    genvar gi;
    generate
        for (gi = 0; gi < pBitVecW; gi++) begin : g_dec
            logic hit;
            always_comb begin
                hit = 1'b0;
                for (int z = 0; z < pDeAlcIO; z++) begin
                    if (bus.DeAllocReq[z] && (bus.DeAllocPhy[z] == NW'(gi)))
                        hit = 1'b1;
                end
            end
            assign dealloc_set[gi] = (pHwPhy0 != 0 && gi == 0) ? 1'b0 : hit;
        end
    endgenerate

    // Requesting ports take the lowest remaining allocatable names in port order.
    always_comb begin
        avail = ~bv_q;
        if (pEnFwd != 0)
            avail = avail | dealloc_set;
        if (pHwPhy0 != 0)
            avail[0] = 1'b0;
        remain     = avail;
        grant_set  = '0;
        alloc_vld  = '0;
        alloc_phy  = '0;
        pick_found = 1'b0;
        for (int p = 0; p < pAlcIO; p++) begin
            if (bus.AllocReq[p] && !bus.RestoreReq && !Clr) begin
                pick_found = 1'b0;
                for (int n = 0; n < pBitVecW; n++) begin
                    if (!pick_found && remain[n]) begin
                        pick_found   = 1'b1;
                        remain[n]    = 1'b0;
                        grant_set[n] = 1'b1;
                        alloc_vld[p] = 1'b1;
                        alloc_phy[p] = NW'(n);
                    end
                end
            end
        end
    end

    // Descending scan leaves the lowest invalid slot selected.
    always_comb begin
        ckpt_vld = 1'b0;
        ckpt_id  = '0;
        if (bus.CkptReq && !bus.RestoreReq && !Clr) begin
            for (int s = pCkpt - 1; s >= 0; s--) begin
                if (!cv_q[s]) begin
                    ckpt_vld = 1'b1;
                    ckpt_id  = CW'(s);
                end
            end
        end
    end

    always_comb begin
        bv_d = (bv_q & ~dealloc_set) | grant_set;
        if (bus.RestoreReq)
            bv_d = sv_q[bus.RestoreId] & ~dealloc_set;
        if (pHwPhy0 != 0)
            bv_d[0] = 1'b1;

        cv_d = cv_q;
        if (bus.RestoreReq)
            cv_d[bus.RestoreId] = 1'b0;
        if (ckpt_vld)
            cv_d[ckpt_id] = 1'b1;
        // Only slots valid before this cycle can be released; a fresh write survives.
        cv_d = cv_d & ~(bus.CkptFreeMask & cv_q);

        // Name 0 is pinned busy when reserved, so a plain zero count suffices.
        free_cnt_d = '0;
        for (int n = 0; n < pBitVecW; n++) begin
            if (!bv_d[n])
                free_cnt_d = free_cnt_d + FW'(1);
        end
        empty_d = (free_cnt_d == '0);
        full_d  = &cv_d;

        for (int s = 0; s < pCkpt; s++) begin
            sv_d[s] = sv_q[s];
            if (ckpt_vld && ckpt_id == CW'(s))
                sv_d[s] = bv_d;
            else if (cv_q[s])
                sv_d[s] = sv_q[s] & ~dealloc_set;
            if (pHwPhy0 != 0)
                sv_d[s][0] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            bv_q       <= BV_RST;
            cv_q       <= '0;
            free_cnt_q <= CNT_RST;
            empty_q    <= 1'b0;
            full_q     <= 1'b0;
            for (int s = 0; s < pCkpt; s++)
                sv_q[s] <= BV_RST;
        end else begin
            bv_q       <= bv_d;
            cv_q       <= cv_d;
            free_cnt_q <= free_cnt_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            for (int s = 0; s < pCkpt; s++)
                sv_q[s] <= sv_d[s];
        end
    end

    assign bus.AllocVld      = alloc_vld;
    assign bus.AllocPhy      = alloc_phy;
    assign bus.CkptVld       = ckpt_vld;
    assign bus.CkptId        = ckpt_id;
    assign bus.CkptFull      = full_q;
    assign bus.FreeCnt       = free_cnt_q;
    assign bus.FreeListEmpty = empty_q;
endmodule

// File: tb/tb_free_list_ckpt.sv
// Directed checks of the checkpointed free list at its default parameters.
module tb_free_list_ckpt;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    free_list_ckpt_if #(.pBitVecW(16), .pAlcIO(4), .pDeAlcIO(8), .pCkpt(4)) bus ();

    free_list_ckpt #(
        .pBitVecW(16), .pAlcIO(4), .pDeAlcIO(8), .pCkpt(4), .pHwPhy0(1), .pEnFwd(1)
    ) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (bus)
    );

    task automatic idle();
        bus.AllocReq     = '0;
        bus.DeAllocReq   = '0;
        bus.DeAllocPhy   = '0;
        bus.CkptReq      = 1'b0;
        bus.CkptFreeMask = '0;
        bus.RestoreReq   = 1'b0;
        bus.RestoreId    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        clr = 1'b1;
        bus.AllocReq = 4'b1111;
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b0000) begin
            $display("FAIL reset_vld got %b want %b", bus.AllocVld, 4'b0000); n_fail++;
        end
        tick();
        clr = 1'b0;
        idle();
        n_cmp++;
        if (bus.FreeCnt !== 5'd15) begin
            $display("FAIL reset_cnt got %0d want 15", bus.FreeCnt); n_fail++;
        end
        n_cmp++;
        if ({bus.FreeListEmpty, bus.CkptFull} !== 2'b00) begin
            $display("FAIL reset_flags got %b want 00", {bus.FreeListEmpty, bus.CkptFull}); n_fail++;
        end
        $display("test_reset done");
    endtask

    task automatic test_alloc_all_ports();
        do_reset();
        bus.AllocReq = 4'b1111;
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b1111 || bus.AllocPhy !== 16'h4321) begin
            $display("FAIL alloc4 got vld=%b phy=%h want vld=1111 phy=4321", bus.AllocVld, bus.AllocPhy); n_fail++;
        end
        tick();
        idle();
        n_cmp++;
        if (bus.FreeCnt !== 5'd11) begin
            $display("FAIL alloc4_cnt got %0d want 11", bus.FreeCnt); n_fail++;
        end
        $display("test_alloc_all_ports done");
    endtask

    task automatic test_sparse_req();
        do_reset();
        bus.AllocReq = 4'b1010;
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b1010 || bus.AllocPhy !== 16'h2010) begin
            $display("FAIL sparse got vld=%b phy=%h want vld=1010 phy=2010", bus.AllocVld, bus.AllocPhy); n_fail++;
        end
        tick();
        idle();
        n_cmp++;
        if (bus.FreeCnt !== 5'd13) begin
            $display("FAIL sparse_cnt got %0d want 13", bus.FreeCnt); n_fail++;
        end
        $display("test_sparse_req done");
    endtask

    task automatic test_exhaust_fwd();
        do_reset();
        bus.AllocReq = 4'b1111;
        for (int c = 0; c < 3; c++) tick();
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b0111 || bus.AllocPhy !== 16'h0FED) begin
            $display("FAIL exhaust_last got vld=%b phy=%h want vld=0111 phy=0fed", bus.AllocVld, bus.AllocPhy); n_fail++;
        end
        tick();
        n_cmp++;
        if (bus.FreeCnt !== 5'd0 || bus.FreeListEmpty !== 1'b1) begin
            $display("FAIL exhaust_empty got cnt=%0d empty=%b want cnt=0 empty=1", bus.FreeCnt, bus.FreeListEmpty); n_fail++;
        end
        bus.AllocReq = 4'b0001;
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b0000) begin
            $display("FAIL exhaust_nogrant got %b want 0000", bus.AllocVld); n_fail++;
        end
        tick();
        bus.DeAllocReq    = 8'b0000_0001;
        bus.DeAllocPhy[0] = 4'd7;
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b0001 || bus.AllocPhy !== 16'h0007) begin
            $display("FAIL fwd got vld=%b phy=%h want vld=0001 phy=0007", bus.AllocVld, bus.AllocPhy); n_fail++;
        end
        tick();
        idle();
        n_cmp++;
        if (bus.FreeCnt !== 5'd0 || bus.FreeListEmpty !== 1'b1) begin
            $display("FAIL fwd_empty got cnt=%0d empty=%b want cnt=0 empty=1", bus.FreeCnt, bus.FreeListEmpty); n_fail++;
        end
        $display("test_exhaust_fwd done");
    endtask

    task automatic test_ckpt_restore();
        do_reset();
        bus.AllocReq = 4'b1111;
        bus.CkptReq  = 1'b1;
        #2;
        n_cmp++;
        if (bus.CkptVld !== 1'b1 || bus.CkptId !== 2'd0) begin
            $display("FAIL ckpt0 got vld=%b id=%0d want vld=1 id=0", bus.CkptVld, bus.CkptId); n_fail++;
        end
        tick();
        bus.CkptReq = 1'b0;
        #2;
        n_cmp++;
        if (bus.AllocPhy !== 16'h8765) begin
            $display("FAIL alloc5_8 got %h want 8765", bus.AllocPhy); n_fail++;
        end
        tick();
        idle();
        bus.DeAllocReq    = 8'b0000_0100;
        bus.DeAllocPhy[2] = 4'd2;
        tick();
        idle();
        bus.RestoreReq = 1'b1;
        bus.RestoreId  = 2'd0;
        bus.AllocReq   = 4'b1111;
        bus.CkptReq    = 1'b1;
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b0000 || bus.CkptVld !== 1'b0) begin
            $display("FAIL restore_block got vld=%b ckpt=%b want 0000/0", bus.AllocVld, bus.CkptVld); n_fail++;
        end
        tick();
        idle();
        n_cmp++;
        if (bus.FreeCnt !== 5'd12) begin
            $display("FAIL restore_cnt got %0d want 12", bus.FreeCnt); n_fail++;
        end
        bus.AllocReq = 4'b1111;
        bus.CkptReq  = 1'b1;
        #2;
        n_cmp++;
        if (bus.AllocPhy !== 16'h7652 || bus.AllocVld !== 4'b1111) begin
            $display("FAIL restore_bv got vld=%b phy=%h want vld=1111 phy=7652", bus.AllocVld, bus.AllocPhy); n_fail++;
        end
        n_cmp++;
        if (bus.CkptVld !== 1'b1 || bus.CkptId !== 2'd0) begin
            $display("FAIL restore_slotfree got vld=%b id=%0d want vld=1 id=0", bus.CkptVld, bus.CkptId); n_fail++;
        end
        tick();
        idle();
        $display("test_ckpt_restore done");
    endtask

    task automatic test_ckpt_full();
        do_reset();
        bus.CkptReq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_cmp++;
            if (bus.CkptVld !== 1'b1 || bus.CkptId !== 2'(k)) begin
                $display("FAIL ckpt_seq%0d got vld=%b id=%0d want vld=1 id=%0d", k, bus.CkptVld, bus.CkptId, k); n_fail++;
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.CkptFull !== 1'b0) begin
                    $display("FAIL ckpt_notfull got %b want 0", bus.CkptFull); n_fail++;
                end
            end
            tick();
        end
        n_cmp++;
        if (bus.CkptFull !== 1'b1) begin
            $display("FAIL ckpt_full got %b want 1", bus.CkptFull); n_fail++;
        end
        #2;
        n_cmp++;
        if (bus.CkptVld !== 1'b0 || bus.CkptId !== 2'd0) begin
            $display("FAIL ckpt_fifth got vld=%b id=%0d want vld=0 id=0", bus.CkptVld, bus.CkptId); n_fail++;
        end
        tick();
        idle();
        bus.CkptFreeMask = 4'b0100;
        tick();
        idle();
        n_cmp++;
        if (bus.CkptFull !== 1'b0) begin
            $display("FAIL ckpt_released got full=%b want 0", bus.CkptFull); n_fail++;
        end
        bus.CkptReq = 1'b1;
        #2;
        n_cmp++;
        if (bus.CkptVld !== 1'b1 || bus.CkptId !== 2'd2) begin
            $display("FAIL ckpt_reuse got vld=%b id=%0d want vld=1 id=2", bus.CkptVld, bus.CkptId); n_fail++;
        end
        tick();
        idle();
        n_cmp++;
        if (bus.CkptFull !== 1'b1) begin
            $display("FAIL ckpt_refull got %b want 1", bus.CkptFull); n_fail++;
        end
        $display("test_ckpt_full done");
    endtask

    task automatic test_clr_mid();
        do_reset();
        bus.AllocReq = 4'b1111;
        bus.CkptReq  = 1'b1;
        tick();
        clr = 1'b1;
        #2;
        n_cmp++;
        if (bus.AllocVld !== 4'b0000 || bus.CkptVld !== 1'b0 || bus.AllocPhy !== 16'h0000) begin
            $display("FAIL clr_block got vld=%b ckpt=%b phy=%h want 0000/0/0000", bus.AllocVld, bus.CkptVld, bus.AllocPhy); n_fail++;
        end
        tick();
        clr = 1'b0;
        idle();
        n_cmp++;
        if (bus.FreeCnt !== 5'd15 || bus.FreeListEmpty !== 1'b0 || bus.CkptFull !== 1'b0) begin
            $display("FAIL clr_state got cnt=%0d empty=%b full=%b want 15/0/0", bus.FreeCnt, bus.FreeListEmpty, bus.CkptFull); n_fail++;
        end
        bus.AllocReq = 4'b1111;
        bus.CkptReq  = 1'b1;
        #2;
        n_cmp++;
        if (bus.AllocPhy !== 16'h4321 || bus.CkptId !== 2'd0 || bus.CkptVld !== 1'b1) begin
            $display("FAIL clr_after got phy=%h id=%0d ckpt=%b want 4321/0/1", bus.AllocPhy, bus.CkptId, bus.CkptVld); n_fail++;
        end
        tick();
        idle();
        $display("test_clr_mid done");
    endtask

    initial begin
        idle();
        test_reset();
        test_alloc_all_ports();
        test_sparse_req();
        test_exhaust_fwd();
        test_ckpt_restore();
        test_ckpt_full();
        test_clr_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/free_list_ckpt.md
FREE_LIST_CKPT -- requirements
Module: free_list_ckpt

Interface
REQ-001 Parameter pBitVecW, 16, number of physical names; names are 0..pBitVecW-1.
REQ-002 Parameter pAlcIO, 4, allocation ports.
REQ-003 Parameter pDeAlcIO, 8, deallocation ports.
REQ-004 Parameter pCkpt, 4, checkpoint slots (>=1).
REQ-005 Parameter pHwPhy0, 1, when 1 name 0 is never allocated, never freed and never counted.
REQ-006 Parameter pEnFwd, 1, when 1 names deallocated this cycle are allocatable this cycle.
REQ-007 Clk  in  1  clock; all state updates on rising edge.
REQ-008 Clr  in  1  reset, synchronous, active-high.
REQ-009 AllocReq  in  pAlcIO  per-port allocation request.
REQ-010 AllocVld  out  pAlcIO  per-port grant.
REQ-011 AllocPhy  out  pAlcIO x clog2(pBitVecW)  granted name per port; 0 when not granted.
REQ-012 DeAllocReq  in  pDeAlcIO  per-port free request.
REQ-013 DeAllocPhy  in  pDeAlcIO x clog2(pBitVecW)  name to free.
REQ-014 CkptReq  in  1  take a checkpoint.
REQ-015 CkptVld  out  1  checkpoint taken this cycle.
REQ-016 CkptId  out  clog2(pCkpt) (min 1)  slot used; 0 when CkptVld=0.
REQ-017 CkptFull  out  1  registered; all slots valid.
REQ-018 CkptFreeMask  in  pCkpt  slots released this cycle.
REQ-019 RestoreReq  in  1  roll back to a checkpoint.
REQ-020 RestoreId  in  clog2(pCkpt) (min 1)  slot to restore.
REQ-021 FreeCnt  out  clog2(pBitVecW+1)  registered count of free names in busy vector.
REQ-022 FreeListEmpty  out  1  registered; FreeCnt==0.

Function
REQ-023 State: busy vector BV[pBitVecW] (1=allocated), per-slot snapshot SV[pCkpt][pBitVecW], slot valid CV[pCkpt], FreeCnt register.
REQ-024 Dealloc set D = names n with any DeAllocReq[z] and DeAllocPhy[z]==n; duplicates and already-free names are harmless; name 0 ignored when pHwPhy0=1.
REQ-025 Allocatable set A = ~BV, plus D when pEnFwd=1; name 0 excluded when pHwPhy0=1.
REQ-026 Grants combinational, same cycle: the j-th requesting port (ascending port index, j from 0) gets the j-th lowest name in A; AllocVld=0 if A has fewer than j+1 names; non-requesting ports consume nothing.
REQ-027 Granted names unique within a cycle and never a name in BV unless freed by D this cycle.
REQ-028 Normal next state: BV' = (BV & ~D) | G, G = granted names.
REQ-029 CkptReq with some CV==0 and no RestoreReq: CkptVld=1, CkptId = lowest invalid slot, SV[CkptId] <= BV', CV[CkptId] <= 1.
REQ-030 CkptReq with all slots valid: CkptVld=0, no state change for slots.
REQ-031 Every valid slot (not being written) updates SV <= SV & ~D each cycle so committed frees survive a restore.
REQ-032 RestoreReq: AllocVld all 0; CkptVld=0; BV' = SV[RestoreId] & ~D; RestoreId slot invalidated; RestoreId pointing at an invalid slot is a protocol error, behaviour undefined.
REQ-033 CkptFreeMask clears CV of masked slots; applied after REQ-029, so a slot freed and written the same cycle ends invalid only if it was already valid before the cycle (newly written slot stays valid).
REQ-034 FreeCnt' = popcount(~BV') excluding name 0 when pHwPhy0=1; FreeListEmpty' = (FreeCnt'==0); CkptFull' = &CV'.
REQ-035 Bit 0 of BV and every SV held at 1 when pHwPhy0=1.

Reset
REQ-036 Clr=1: BV=0 (bit 0 =1 if pHwPhy0), SV=0, CV=0, FreeCnt=pBitVecW-pHwPhy0, FreeListEmpty=0, CkptFull=0; Clr overrides all requests same cycle; AllocVld/CkptVld forced 0 while Clr=1.

Verification (defaults)
REQ-037 After reset, AllocReq=4'b1111 -> AllocPhy 1,2,3,4 all valid; next cycle FreeCnt=11.
REQ-038 AllocReq=4'b1010 after reset -> port1 gets 1, port3 gets 2, ports 0/2 AllocVld=0.
REQ-039 Allocate all 15 over 4 cycles -> FreeListEmpty=1; next cycle DeAllocPhy=7 with AllocReq[0] -> pEnFwd=1 grants 7, FreeListEmpty stays 1.
REQ-040 Alloc 1-4, CkptReq -> CkptId=0; alloc 5-8; dealloc 2; RestoreReq Id 0 -> BV holds {0,1,3,4}, FreeCnt=12, CV[0]=0.
REQ-041 Four CkptReq -> CkptId 0,1,2,3, CkptFull=1; fifth CkptVld=0; CkptFreeMask=4'b0100 -> next CkptReq gets Id 2.
REQ-042 Clr asserted with AllocReq and CkptReq high mid-operation -> no grants, state equals REQ-036 values next cycle.
